// File: rtl/team_06_i2s_tx_serializer.sv
// Buffers parallel samples in a small FIFO and serializes them as Philips I2S (mono on both slots).
// Build option: define TEAM_06_I2S_TX_HOLD_EN to repeat the last popped sample on underflow instead of zeros.
module team_06_i2s_tx_serializer #(
    parameter int SAMPLE_W   = 9,
    parameter int SLOT_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                bclk,
    output logic                ws,
    output logic                sd,
    output logic                fifo_full,
    output logic                overflow,
    output logic                underflow
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(2 * SLOT_W);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                bclk_q, bclk_d;
    logic                ws_q, ws_d;
    logic                sd_q, sd_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                fresh_q, fresh_d;
    logic [SAMPLE_W-1:0] frame_q, frame_d;
    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
`ifdef TEAM_06_I2S_TX_HOLD_EN
    logic [SAMPLE_W-1:0] last_q, last_d;
`endif

    logic                div_tc, fall, frame_start, stop, pop, push, is_empty, is_full;
    logic [CNT_W-1:0]    k_next, slot_idx;
    logic [SAMPLE_W-1:0] new_sample, cur_sample;
    logic [SLOT_W-1:0]   word_sh;

    assign div_tc   = (div_q == DIV_W'(BCLK_DIV - 1));
    assign fall     = (state_q == RUN) && div_tc && bclk_q;
    // fresh_q marks "no falling edge yet since leaving IDLE": bit_cnt counts as the last bit of a frame.
    assign k_next   = (fresh_q || bit_cnt_q == CNT_W'(2 * SLOT_W - 1)) ? '0 : bit_cnt_q + CNT_W'(1);
    assign frame_start = fall && (k_next == '0);
    assign stop     = frame_start && !enable;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == OCC_W'(FIFO_DEPTH));
    // sample_valid is a push strobe with no ready: it is accepted unless the FIFO is full and no pop frees a slot.
    assign pop      = frame_start && !stop && !is_empty;
    assign push     = sample_valid && (!is_full || pop);

`ifdef TEAM_06_I2S_TX_HOLD_EN
    assign new_sample = pop ? mem_q[rd_ptr_q] : last_q;
`else
    assign new_sample = pop ? mem_q[rd_ptr_q] : '0;
`endif
    assign cur_sample = frame_start ? new_sample : frame_q;
    assign slot_idx   = (k_next >= CNT_W'(SLOT_W)) ? k_next - CNT_W'(SLOT_W) : k_next;
    assign word_sh    = (SLOT_W'(cur_sample) << (SLOT_W - SAMPLE_W)) << slot_idx;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (stop)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d     = div_q;
        bclk_d    = bclk_q;
        ws_d      = ws_q;
        sd_d      = sd_q;
        bit_cnt_d = bit_cnt_q;
        fresh_d   = fresh_q;
        frame_d   = frame_q;
        unf_d     = unf_q;
        if (state_q == IDLE) begin
            div_d     = '0;
            bclk_d    = 1'b0;
            ws_d      = 1'b0;
            sd_d      = 1'b0;
            bit_cnt_d = '0;
            fresh_d   = 1'b1;
        end else begin
            div_d = div_tc ? '0 : div_q + DIV_W'(1);
            if (div_tc) bclk_d = ~bclk_q;
            if (fall) begin
                fresh_d   = 1'b0;
                bit_cnt_d = k_next;
                if (stop) begin
                    ws_d = 1'b0;
                    sd_d = 1'b0;
                end else begin
                    ws_d = (k_next >= CNT_W'(SLOT_W - 1)) && (k_next <= CNT_W'(2 * SLOT_W - 2));
                    sd_d = word_sh[SLOT_W-1];
                    if (frame_start) begin
                        frame_d = new_sample;
                        if (is_empty) unf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = sample_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + OCC_W'(push) - OCC_W'(pop);
        ovf_d   = ovf_q | (sample_valid && !push);
    end

`ifdef TEAM_06_I2S_TX_HOLD_EN
    assign last_d = pop ? mem_q[rd_ptr_q] : last_q;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            ws_q      <= 1'b0;
            sd_q      <= 1'b0;
            bit_cnt_q <= '0;
            fresh_q   <= 1'b1;
            frame_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
`ifdef TEAM_06_I2S_TX_HOLD_EN
            last_q    <= '0;
`endif
        end else begin
            div_q     <= div_d;
            bclk_q    <= bclk_d;
            ws_q      <= ws_d;
            sd_q      <= sd_d;
            bit_cnt_q <= bit_cnt_d;
            fresh_q   <= fresh_d;
            frame_q   <= frame_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
`ifdef TEAM_06_I2S_TX_HOLD_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bclk      = bclk_q;
    assign ws        = ws_q;
    assign sd        = sd_q;
    assign fifo_full = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_team_06_i2s_tx_serializer.sv
// Bench for the I2S serializer: cycle-level reference built from bclk timing arithmetic and a sample queue.
module tb_team_06_i2s_tx_serializer;
    localparam int SAMPLE_W   = 9;
    localparam int SLOT_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int BCLK_DIV   = 4;

    logic                clk = 1'b0;
    logic                nrst = 1'b1;
    logic                enable = 1'b0;
    logic                sample_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample_in = '0;
    logic                bclk, ws, sd, fifo_full, overflow, underflow;

    team_06_i2s_tx_serializer #(
        .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .FIFO_DEPTH(FIFO_DEPTH), .BCLK_DIV(BCLK_DIV)
    ) dut (
        .clk(clk), .nrst(nrst), .enable(enable), .sample_in(sample_in), .sample_valid(sample_valid),
        .bclk(bclk), .ws(ws), .sd(sd), .fifo_full(fifo_full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: samples waiting in the FIFO, plus run time since leaving IDLE.
    logic [SAMPLE_W-1:0] exp_q[$];
    bit                  m_run;
    int                  m_n;
    logic [SAMPLE_W-1:0] m_fs, m_last;
    logic                m_bclk, m_ws, m_sd, m_ovf, m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_run = 0; m_n = 0; m_fs = '0; m_last = '0;
        m_bclk = 0; m_ws = 0; m_sd = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_edge();
        int m, k, idx;
        if (!m_run) begin
            m_bclk = 0; m_ws = 0; m_sd = 0;
            if (enable) begin
                m_run = 1;
                m_n   = 0;
            end
        end else begin
            m_n++;
            m_bclk = ((m_n / BCLK_DIV) % 2) == 1;
            if (m_n % (2 * BCLK_DIV) == 0) begin
                m = m_n / (2 * BCLK_DIV);
                k = (m - 1) % (2 * SLOT_W);
                if (k == 0 && !enable) begin
                    m_run = 0; m_ws = 0; m_sd = 0; m_bclk = 0;
                end else begin
                    if (k == 0) begin
                        if (exp_q.size() > 0) begin
                            m_fs   = exp_q.pop_front();
                            m_last = m_fs;
                        end else begin
                            m_unf = 1;
`ifdef TEAM_06_I2S_TX_HOLD_EN
                            m_fs = m_last;
`else
                            m_fs = '0;
`endif
                        end
                    end
                    m_ws = (k >= SLOT_W - 1) && (k <= 2 * SLOT_W - 2);
                    idx  = k % SLOT_W;
                    m_sd = (idx < SAMPLE_W) ? m_fs[SAMPLE_W-1-idx] : 1'b0;
                end
            end
        end
        if (sample_valid) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(sample_in);
            else m_ovf = 1;
        end
    endtask

    task automatic check_outputs();
        check("bclk", 32'(bclk), 32'(m_bclk));
        check("ws", 32'(ws), 32'(m_ws));
        check("sd", 32'(sd), 32'(m_sd));
        check("fifo_full", 32'(fifo_full), 32'(exp_q.size() == FIFO_DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic en, input logic valid, input logic [SAMPLE_W-1:0] data);
        enable = en; sample_valid = valid; sample_in = data;
        tick();
    endtask

    task automatic run(input int cycles, input logic en, input int push_pct);
        for (int i = 0; i < cycles; i++)
            drive(en, $urandom_range(0, 99) < push_pct, SAMPLE_W'($urandom_range(0, (1 << SAMPLE_W) - 1)));
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear before any edge.
    task automatic mid_reset();
        #1;
        nrst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        enable = 0; sample_valid = 0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    endtask

    initial begin
        model_reset();
        #1 nrst = 1'b0;
        #1 check_outputs();
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        run(5, 0, 0);

        // Single sample, one full frame, then a zero underflow frame.
        drive(0, 1, 9'h1A5);
        run(3, 0, 0);
        run(2 * BCLK_DIV + 256 + 100, 1, 0);
        run(300, 0, 0);

        // Three samples in order, then an underflow frame; enable drops near k=5 of frame four.
        mid_reset();
        drive(0, 1, 9'h1A5);
        drive(0, 1, 9'h0FF);
        drive(0, 1, 9'h100);
        run(2, 0, 0);
        run(2 * BCLK_DIV + 256 * 3 + 41, 1, 0);
        run(300, 0, 0);

        // Five pushes into a four-entry FIFO, then reset in the middle of a running frame.
        mid_reset();
        for (int i = 0; i < 5; i++) drive(0, 1, SAMPLE_W'($urandom_range(1, (1 << SAMPLE_W) - 1)));
        run(2, 0, 0);
        run(2 * BCLK_DIV + 256 * 4 + 8 * 21 + 5, 1, 0);
        mid_reset();

        // Push on the very edge of the first frame-start pop while full.
        for (int i = 0; i < 4; i++) drive(0, 1, SAMPLE_W'($urandom_range(0, (1 << SAMPLE_W) - 1)));
        drive(1, 0, '0);
        run(2 * BCLK_DIV - 1, 1, 0);
        drive(1, 1, SAMPLE_W'($urandom_range(0, (1 << SAMPLE_W) - 1)));
        run(256 * 3, 1, 0);
        run(300, 0, 0);

        // Randomized enable windows and sparse pushes.
        mid_reset();
        for (int i = 0; i < 24; i++)
            run($urandom_range(40, 500), $urandom_range(0, 3) != 0, $urandom_range(0, 3));
        run(600, 0, 0);

        summary();
        $finish;
    end

    initial begin
        #3ms;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $fatal(1, "watchdog expired");
    end
endmodule
